// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int DEPTH_DEF  = 256;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_width_t;

    // Byte-lane enables for a store of the given width at a byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (f3)
            LB:      m = 4'b0001 << off;
            LH:      m = 4'b0011 << off;
            LW:      m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_ext.sv
// Load lane selection and sign/zero extension of the raw memory word.
module load_ext
    import lsu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic [DWIDTH-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        half_sel = word_i[15:0];
        case (off_i)
            2'd0: begin
                byte_sel = word_i[7:0];
                half_sel = word_i[15:0];
            end
            2'd1: begin
                byte_sel = word_i[15:8];
                half_sel = word_i[23:8];
            end
            2'd2: begin
                byte_sel = word_i[23:16];
                half_sel = word_i[31:16];
            end
            default: begin
                byte_sel = word_i[31:24];
                half_sel = {8'h00, word_i[31:24]};
            end
        endcase
    end

    always_comb begin
        data_o = '0;
        case (funct3_i)
            LB:      data_o = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            LBU:     data_o = {{(DWIDTH-8){1'b0}}, byte_sel};
            LH:      data_o = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            LHU:     data_o = {{(DWIDTH-16){1'b0}}, half_sel};
            LW:      data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with byte/half/word loads and stores,
// misalignment detection and a sticky first-error capture register.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ALUResult,
    input  logic [DWIDTH-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [2:0]        Funct3,
    input  logic              ErrClr,
    output logic [DWIDTH-1:0] ReadData,
    output logic              MisAlign,
    output logic              ErrSticky,
    output logic [DWIDTH-1:0] ErrAddr
);

    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]     idx;
    logic [1:0]        off;
    logic              illegal;
    logic              bad_align;
    logic              mis;
    logic [DWIDTH-1:0] cur_word;
    logic [DWIDTH-1:0] ext_data;
    logic [3:0]        be;
    logic [31:0]       sdata;
    logic [DWIDTH-1:0] wword_d;
    logic              we;

    logic              err_sticky_q, err_sticky_d;
    logic [DWIDTH-1:0] err_addr_q, err_addr_d;

    assign idx      = ALUResult[AW+1:2];
    assign off      = ALUResult[1:0];
    assign cur_word = mem_q[idx];

    // Unsigned widths only exist for loads; any store using them is illegal.
    always_comb begin
        illegal   = 1'b0;
        bad_align = 1'b0;
        case (Funct3)
            LB:  bad_align = 1'b0;
            LH:  bad_align = off[0];
            LW:  bad_align = |off;
            LBU: illegal   = MemWrite;
            LHU: begin
                illegal   = MemWrite;
                bad_align = off[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign mis      = (MemRead | MemWrite) & (illegal | bad_align);
    assign MisAlign = mis;

    load_ext #(
        .DWIDTH(DWIDTH)
    ) u_load_ext (
        .word_i  (cur_word),
        .off_i   (off),
        .funct3_i(Funct3),
        .data_o  (ext_data)
    );

    assign ReadData = (MemRead && !mis) ? ext_data : '0;

    always_comb begin
        be    = lane_mask(Funct3, off);
        sdata = WriteData[31:0];
        case (Funct3)
            LB:      sdata = {4{WriteData[7:0]}};
            LH:      sdata = {2{WriteData[15:0]}};
            default: sdata = WriteData[31:0];
        endcase
        wword_d = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                wword_d[8*i +: 8] = sdata[8*i +: 8];
            end
        end
        we = MemWrite && !mis && !reset;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wword_d;
        end
    end

    // A new error overrides a simultaneous clear and restarts capture.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (mis) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q || ErrClr) begin
                err_addr_d = ALUResult;
            end
        end else if (ErrClr) begin
            err_sticky_d = 1'b0;
            err_addr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign ErrSticky = err_sticky_q;
    assign ErrAddr   = err_addr_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu with a byte-array reference model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  Funct3;
    logic        ErrClr;
    logic [31:0] ReadData;
    logic        MisAlign;
    logic        ErrSticky;
    logic [31:0] ErrAddr;

    always #5 clk = ~clk;

    data_mem_lsu #(
        .DWIDTH(32),
        .DEPTH (256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Funct3   (Funct3),
        .ErrClr   (ErrClr),
        .ReadData (ReadData),
        .MisAlign (MisAlign),
        .ErrSticky(ErrSticky),
        .ErrAddr  (ErrAddr)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        st;
        logic [31:0] ea;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    logic [7:0]  mem_b [1024];
    logic        m_st;
    logic [31:0] m_ea;

    task automatic chk(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s tag=%0d got=%h exp=%h", nm, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ReadData", e.tag, ReadData, e.rd);
            chk("MisAlign", e.tag, {31'd0, MisAlign}, {31'd0, e.mis});
            chk("ErrSticky", e.tag, {31'd0, ErrSticky}, {31'd0, e.st});
            chk("ErrAddr", e.tag, ErrAddr, e.ea);
        end
    end

    function automatic logic m_mis(input logic [31:0] a, input logic rd,
                                   input logic wr, input logic [2:0] f3);
        if (!(rd || wr)) return 1'b0;
        case (f3)
            3'd0: return 1'b0;
            3'd1: return a[0];
            3'd2: return a[1:0] != 2'd0;
            3'd4: return wr;
            3'd5: return wr || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [2:0] f3);
        int b;
        int w;
        logic [15:0] h;
        b = int'(a % 1024);
        w = b - (b % 4);
        h = {mem_b[(b + 1) % 1024], mem_b[b]};
        case (f3)
            3'd0: return {{24{mem_b[b][7]}}, mem_b[b]};
            3'd4: return {24'd0, mem_b[b]};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'd0, h};
            3'd2: return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3);
        int b;
        int n;
        b = int'(a % 1024);
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            mem_b[b + i] = wd[8*i +: 8];
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [2:0] f3,
                       input logic clr, input logic rst,
                       input logic use_k, input logic [31:0] k);
        exp_t e;
        logic m;
        @(posedge clk);
        #1;
        ALUResult = a;
        WriteData = wd;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ErrClr    = clr;
        reset     = rst;
        m     = m_mis(a, rd, wr, f3);
        e.mis = m;
        e.rd  = (rd && !m) ? m_load(a, f3) : 32'd0;
        if (use_k) e.rd = k;
        e.st  = m_st;
        e.ea  = m_ea;
        e.tag = tag_n++;
        sb_q.push_back(e);
        if (rst) begin
            m_st = 1'b0;
            m_ea = 32'd0;
        end else begin
            if (wr && !m) m_store(a, wd, f3);
            if (m) begin
                if (!m_st || clr) m_ea = a;
                m_st = 1'b1;
            end else if (clr) begin
                m_st = 1'b0;
                m_ea = 32'd0;
            end
        end
    endtask

    task automatic st_op(input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
        cyc(a, wd, 1'b0, 1'b1, f3, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic ld_k(input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] k);
        cyc(a, 32'd0, 1'b1, 1'b0, f3, 1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic idle(input logic clr);
        cyc(32'd0, 32'd0, 1'b0, 1'b0, 3'd2, clr, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        ALUResult = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Funct3    = 3'd2;
        ErrClr    = 1'b0;
        m_st      = 1'b0;
        m_ea      = 32'd0;
        repeat (2) @(posedge clk);

        idle(1'b0);
        for (int i = 0; i < 256; i++) begin
            st_op((i * 4) | ($urandom & 32'hFFFF_FC00), $urandom, 3'd2);
        end

        st_op(32'h10, 32'h8000_00F1, 3'd2);
        ld_k(32'h10, 3'd0, 32'hFFFF_FFF1);
        ld_k(32'h10, 3'd4, 32'h0000_00F1);
        ld_k(32'h10, 3'd1, 32'h0000_00F1);
        ld_k(32'h10, 3'd5, 32'h0000_00F1);
        ld_k(32'h10, 3'd2, 32'h8000_00F1);

        st_op(32'h20, 32'h1122_3344, 3'd2);
        st_op(32'h22, 32'h0000_00AA, 3'd0);
        ld_k(32'h20, 3'd2, 32'h11AA_3344);
        st_op(32'h20, 32'h0000_BEEF, 3'd1);
        ld_k(32'h20, 3'd2, 32'h11AA_BEEF);

        ld_k(32'h06, 3'd2, 32'd0);
        st_op(32'h13, 32'h0000_1234, 3'd1);
        ld_k(32'h10, 3'd2, 32'h8000_00F1);

        idle(1'b1);
        idle(1'b0);
        cyc(32'h0A, 32'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 32'd0);
        idle(1'b0);

        st_op(32'h400, 32'h0000_0055, 3'd2);
        ld_k(32'h000, 3'd2, 32'h0000_0055);
        st_op(32'h40, 32'h0000_1111, 3'd2);
        cyc(32'h40, 32'h0000_2222, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0,
            1'b1, 32'h0000_1111);
        ld_k(32'h40, 3'd2, 32'h0000_2222);

        st_op(32'h30, 32'hCAFE_0000, 3'd2);
        ld_k(32'h06, 3'd2, 32'd0);
        cyc(32'h30, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1,
            1'b0, 32'd0);
        ld_k(32'h30, 3'd2, 32'hCAFE_0000);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom, $urandom, 1'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0,
                1'b0, 32'd0);
        end

        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        ErrClr   = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
